uart_tx_frame: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises one character per `start` pulse with configurable data width, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits, timed from an oversampled baud tick. It sits between the baud tick generator and the board TX pin, driven by the command/FIFO logic through a `start`/`tx_busy`/`tx_done` handshake.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_tx_frame.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes, legal parameter ranges.
package uart_pkg;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 1;
  localparam int OVERSAMPLE_MAX = 32;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } uart_state_e;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Reserved mode 11 is treated as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: one bit period is OVERSAMPLE ticks, bit_end pulses on the last one.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_bit_end
);

  localparam int            CW   = cnt_width(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] r_tick_cnt;

  assign o_bit_end = i_tick && (r_tick_cnt == LAST);

  // Count ticks, wrap at the end of each bit; clear wins over a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (i_clear) begin
      r_tick_cnt <= '0;
    end else if (i_tick) begin
      r_tick_cnt <= (r_tick_cnt == LAST) ? '0 : r_tick_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data LSB first, optional parity, 1/2 stop.
//
// state  | meaning
// IDLE   | line high, waiting for start; timer held clear
// START  | start bit (low) for one bit period
// DATA   | shifting out data bits, LSB first
// PARITY | even/odd parity bit over the latched character
// STOP   | line high for one or two bit periods, then tx_done
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int            BW       = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_stop2;
  logic                 r_stop_cnt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_bit_end;
  logic                 w_timer_clear;

  // Holding the timer clear in IDLE makes every frame start on a fresh bit
  // period and drops any b_tick coincident with the accepting edge.
  assign w_timer_clear = (r_state == ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timer_clear),
    .i_tick   (b_tick),
    .o_bit_end(w_bit_end)
  );

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift    <= tx_data;
            r_par_en   <= parity_enabled(parity_mode);
            r_par_bit  <= (^tx_data) ^ (parity_mode == PAR_ODD);
            r_stop2    <= stop2;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_BIT) begin
              if (r_par_en) begin
                r_tx    <= r_par_bit;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule
